// File: rtl/demux_dispatch_sched_pkg.sv
// Shared lane geometry and helpers for the round-robin dispatch scheduler.
package demux_dispatch_sched_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 2;
    localparam int unsigned OCC_W     = 4;

    typedef logic [LANE_W-1:0]    lane_idx_t;
    typedef logic [NUM_LANES-1:0] lane_vec_t;

    function automatic lane_vec_t lane_onehot(input lane_idx_t idx);
        lane_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requesting lane at or after ptr.
module rr_pick4
    import demux_dispatch_sched_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       any
);

    lane_idx_t idx;

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int unsigned k = NUM_LANES; k > 0; k--) begin
            idx = ptr + lane_idx_t'(k - 1);
            if (req[idx]) begin
                gnt_idx = idx;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_dispatch_sched.sv
// One-entry dispatch register feeding a 1-to-4 demux, with round-robin lane
// choice and per-lane occupancy counters.
module demux_dispatch_sched
    import demux_dispatch_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OCC   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [3:0]       lane_ready,
    output logic [3:0]       lane_valid,
    output logic [1:0]       demux_sel,
    output logic [WIDTH-1:0] demux_data,
    output logic [3:0]       lane_busy
);

    logic             full_q, full_d;
    lane_idx_t        tgt_q, tgt_d;
    lane_idx_t        ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [OCC_W-1:0] cnt_q [NUM_LANES];
    logic [OCC_W-1:0] cnt_d [NUM_LANES];

    lane_vec_t busy;
    lane_vec_t free;
    logic      done;
    logic      load;
    logic      pick_any;
    lane_idx_t pick_idx;

    // The pending lane is not free even if it accepts this cycle: it turns busy.
    always_comb begin
        busy = '0;
        free = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            busy[i] = (cnt_q[i] != '0);
            free[i] = !busy[i] && !(full_q && (tgt_q == lane_idx_t'(i)));
        end
    end

    rr_pick4 u_pick (
        .req     (free),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign done     = full_q && lane_ready[tgt_q];
    assign in_ready = !reset && (!full_q || done) && pick_any;
    assign load     = in_valid && in_ready;

    always_comb begin
        full_d = full_q;
        tgt_d  = tgt_q;
        ptr_d  = ptr_q;
        data_d = data_q;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (done && (tgt_q == lane_idx_t'(i))) begin
                cnt_d[i] = OCC_W'(OCC);
            end else if (busy[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        if (load) begin
            full_d = 1'b1;
            tgt_d  = pick_idx;
            ptr_d  = pick_idx + 1'b1;
            data_d = in_data;
        end else if (done) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            tgt_q  <= '0;
            ptr_q  <= '0;
            data_q <= '0;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            full_q <= full_d;
            tgt_q  <= tgt_d;
            ptr_q  <= ptr_d;
            data_q <= data_d;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign lane_valid = (full_q && !reset) ? lane_onehot(tgt_q) : '0;
    assign demux_sel  = reset ? '0 : tgt_q;
    assign demux_data = reset ? '0 : data_q;
    assign lane_busy  = reset ? '0 : busy;

endmodule

// File: doc/demux_dispatch_sched.md
# demux_dispatch_sched

Round-robin dispatch scheduler for a 32-bit 1-to-4 demux in the superscalar issue path. Accepts one 32-bit word per handshake and holds it in a one-entry output register. Picks a destination lane not currently occupied, then drives the demux select, data and a one-hot lane valid until that lane accepts. Per-lane occupancy counters stop a lane from receiving a new word for OCC cycles after each accept.

## Interface
- WIDTH, 32, data word width.
- OCC, 2, cycles a lane stays occupied after accepting a word; legal range 1..15.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream word present.
- in_data  in  WIDTH  upstream word.
- in_ready  out  1  scheduler can load `in_data` this cycle.
- lane_ready  in  4  per-lane consumer ready.
- lane_valid  out  4  one-hot: word presented to lane i; all-zero when empty.
- demux_sel  out  2  demux select, equals the target lane index.
- demux_data  out  WIDTH  registered word feeding the demux `d` input.
- lane_busy  out  4  status: lane i occupancy counter nonzero.

## Operation
- State:
  - `full` (1 bit);
  - `tgt` (2 bits);
  - `data_q` (WIDTH bits);
  - `ptr` (2-bit round-robin pointer);
  - `cnt[i]` (4-bit occupancy counter) for each of 4 lanes.
- `done = full && lane_ready[tgt]`. This is the lane handshake.
- `free[i] = (cnt[i]==0) && !(full && tgt==i)`.
- `in_ready = !reset && (!full || done) && |free`.
- Load occurs when `in_valid && in_ready`:
  - `data_q <= in_data`;
  - `tgt <=` first i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with `free[i]`;
  - `ptr <= tgt_new + 1` (mod 4);
  - `full <= 1`.
- On `done` without a load: `full <= 0`. On `done` with a load: `full` stays 1 and the new word replaces the old one with no bubble.
- Counters:
  - On `done`, `cnt[tgt] <= OCC`.
  - Otherwise a nonzero `cnt[i]` decrements by 1.
  - Counters saturate at 0 and never wrap.
- Outputs:
  - `lane_valid = full ? (1<<tgt) : 0`;
  - `demux_sel = tgt`;
  - `demux_data = data_q`;
  - `lane_busy[i] = (cnt[i]!=0)`.
- `lane_valid` never depends combinationally on `lane_ready`. Once asserted, `lane_valid`, `demux_sel` and `demux_data` hold stable until `done`.
- Lanes with `lane_ready` high but no pending word are ignored.
- Reset mid-operation: the pending word is dropped and every counter and the pointer clear. No lane handshake completes in the reset cycle.

## Timing
- Reset values:
  - `full=0`, `tgt=0`, `ptr=0`, `data_q=0`, all `cnt=0`;
  - outputs `lane_valid=0`, `demux_sel=0`, `demux_data=0`, `lane_busy=0`, `in_ready=0` while reset is high.
- Latency: a load in cycle t produces `lane_valid`/`demux_data` in cycle t+1.
- Throughput: 1 word per cycle while at least one lane is free and the consumers accept immediately.
- Occupancy: an accept on lane i in cycle t gives `cnt[i]=OCC` at t+1 and `cnt[i]=0` at t+1+OCC.
  - Lane i is next loadable in cycle t+1+OCC.
  - Lane i next sees `lane_valid` in cycle t+2+OCC.
- All four lanes busy: `in_ready=0`. The pending word continues to wait on its own lane.
- Stalled consumer: the word waits indefinitely, and `in_ready=0` until `done`.

## Structure
- Shared package:
  - `NUM_LANES=4`;
  - `LANE_W=2`;
  - `OCC_W=4`;
  - a `lane_idx_t` typedef;
  - a one-hot-from-index function.
- One sub-module, `rr_pick4`, a combinational round-robin picker:
  - inputs: `req[3:0]` and `ptr[1:0]`;
  - outputs: `gnt_idx[1:0]` and `any`.
- Counters, the register stage and the handshake logic live in the top module.

## Test plan
- Reset then a stream: reset for 2 cycles, then `in_valid` with words 0xA0..0xA3 back-to-back and `lane_ready=4'hF`, OCC=2.
  - Required: `lane_valid` 0001, 0010, 0100, 1000 on consecutive cycles starting 1 cycle after the first load.
  - `demux_sel` 0,1,2,3, and `demux_data` matches each word.
- Occupancy exhaustion: OCC=4, 6 words back-to-back, all lanes ready.
  - Required: 4 words issue, then `in_ready=0`.
  - Lane 0 is reloaded exactly in cycle t0+5, where t0 is its accept cycle.
  - `lane_busy` reads 1111 during the gap.
- Stalled lane: `lane_ready[1]=0` while word 0xBEEF targets lane 1.
  - Required: `lane_valid=0010` and `demux_data=0xBEEF` stay stable for 10 cycles, with `in_ready=0`.
  - Raising `lane_ready[1]` completes the handshake, and `cnt[1]=OCC` on the next cycle.
- Pointer skip: lanes 1 and 2 busy (`cnt` nonzero) with `ptr=1`, then load one word.
  - Required: `tgt=3`, and `ptr` becomes 0.
- Simultaneous done+load: a new word arrives in the same cycle lane 0 accepts.
  - Required: `full` stays 1, `lane_valid` moves to the next free lane with no empty cycle, and lane 0 is busy.
- Reset mid-operation: assert reset while `full=1` and `cnt[2]=3`.
  - Required: next cycle `lane_valid=0`, `lane_busy=0` and `ptr=0`, and the dropped word never appears.
